// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic {
    StRun  = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam logic [4:0] RegZero = 5'd0;
  localparam int unsigned MultiLatDefault = 4;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Wrapping performance counter with increment enable and async active-low reset.
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and multi-cycle EX freezes,
// plus stall and flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MULTI_LAT = MultiLatDefault,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_multi_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // The RUN cycle that sees ex_multi_start is the first freeze cycle, hence the -2.
  localparam bit         MultiEn  = (MULTI_LAT >= 2);
  localparam logic [3:0] McntInit = MultiEn ? 4'(MULTI_LAT - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic       load_use;
  logic       branch_flush;

  assign load_use = ex_mem_read && (ex_rt != RegZero) &&
                    ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      mcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mcnt_d       = mcnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    branch_flush = 1'b0;

    unique case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          branch_flush = 1'b1;
        end else if (ex_multi_start && MultiEn) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          state_d     = StBusy;
          mcnt_d      = McntInit;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      StBusy: begin
        if (mcnt_q != 4'd0) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          mcnt_d      = mcnt_q - 4'd1;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    // Reset drives a bubble into both front-end registers.
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      branch_flush = 1'b0;
    end
  end

  assign busy = (state_q == StBusy);

  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (~pc_write),
    .count(stall_cycles)
  );

  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (branch_flush),
    .count(flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (32-bit and 4-bit counter instances).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rs = 0, id_uses_rt = 0, ex_mem_read = 0;
  logic        ex_branch_taken = 0, ex_multi_start = 0;

  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, busy;
  logic [31:0] stall_cycles, flush_events;
  logic        pc_write4, if_id_write4, if_id_flush4, id_ex_write4, id_ex_flush4, busy4;
  logic [3:0]  stall_cycles4, flush_events4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULTI_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_multi_start(ex_multi_start),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .busy(busy),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipeline_hazard_ctrl #(.MULTI_LAT(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_multi_start(ex_multi_start),
    .pc_write(pc_write4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
    .id_ex_write(id_ex_write4), .id_ex_flush(id_ex_flush4), .busy(busy4),
    .stall_cycles(stall_cycles4), .flush_events(flush_events4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check all six control outputs as one packed vector {pc,ifw,iff,exw,exf,busy}.
  task automatic check_ctl(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, busy},
          {26'd0, exp});
    check({tag, "_inv"}, {31'd0, id_ex_flush & ~id_ex_write}, 32'd0);
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
    ex_branch_taken = 0; ex_multi_start = 0;
  endtask

  // Advance to the next negedge (inputs are applied there, outputs sampled 1 later).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  localparam logic [5:0] CtlReset  = 6'b001110;
  localparam logic [5:0] CtlRun    = 6'b110100;
  localparam logic [5:0] CtlBubble = 6'b000110;
  localparam logic [5:0] CtlFreeze = 6'b000000;
  localparam logic [5:0] CtlBusyFz = 6'b000001;
  localparam logic [5:0] CtlBusyRl = 6'b110101;
  localparam logic [5:0] CtlBranch = 6'b111110;

  initial begin
    // Reset values
    #2;
    check_ctl("reset_ctl", CtlReset);
    check("reset_stall", stall_cycles, 32'd0);
    check("reset_flush", flush_events, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    #1 check_ctl("idle", CtlRun);

    // 1: load-use on rs
    next_cycle();
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
    #1 check_ctl("lu_rs", CtlBubble);
    check("lu_stall_before", stall_cycles, 32'd0);
    next_cycle();
    clear_inputs();
    #1 check("lu_stall_after", stall_cycles, 32'd1);
    check_ctl("lu_release", CtlRun);

    // 2: $zero destination and unused operand never stall
    next_cycle();
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
    #1 check_ctl("zero_reg", CtlRun);
    next_cycle();
    ex_mem_read = 1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 0; id_uses_rs = 0;
    #1 check_ctl("unused_rt", CtlRun);
    next_cycle();
    id_uses_rt = 1;
    #1 check_ctl("lu_rt", CtlBubble);
    next_cycle();
    clear_inputs();
    #1 check("lu_rt_stall", stall_cycles, 32'd2);

    // 3: multi-cycle op, freeze 3 cycles; a branch while BUSY is ignored
    next_cycle();
    ex_multi_start = 1;
    #1 check_ctl("multi_c1", CtlFreeze);
    next_cycle();
    ex_multi_start = 0; ex_branch_taken = 1;
    #1 check_ctl("multi_c2", CtlBusyFz);
    next_cycle();
    ex_branch_taken = 0;
    #1 check_ctl("multi_c3", CtlBusyFz);
    next_cycle();
    #1 check_ctl("multi_c4", CtlBusyRl);
    next_cycle();
    #1 check_ctl("multi_done", CtlRun);
    check("multi_stall", stall_cycles, 32'd5);
    check("multi_noflush", flush_events, 32'd0);

    // 4: branch beats load-use
    next_cycle();
    ex_branch_taken = 1; ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
    #1 check_ctl("branch_prio", CtlBranch);
    next_cycle();
    clear_inputs();
    #1 check("branch_flush_cnt", flush_events, 32'd1);
    check("branch_stall_cnt", stall_cycles, 32'd5);

    // 5: reset during the second freeze cycle
    next_cycle();
    ex_multi_start = 1;
    next_cycle();
    ex_multi_start = 0;
    #1 check_ctl("rst_mid_busy_pre", CtlBusyFz);
    rst_n = 1'b0;
    #1 check_ctl("rst_mid_busy", CtlReset);
    check("rst_mid_stall", stall_cycles, 32'd0);
    check("rst_mid_flush", flush_events, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    #1 check_ctl("rst_release", CtlRun);
    next_cycle();
    #1 check_ctl("rst_run", CtlRun);
    check("rst_run_stall", stall_cycles, 32'd0);

    // 6: 17 consecutive load-use stalls wrap the 4-bit counter to 1
    next_cycle();
    ex_mem_read = 1; ex_rt = 5'd3; id_rt = 5'd3; id_uses_rt = 1;
    repeat (17) next_cycle();
    clear_inputs();
    #1 check("wrap_stall4", {28'd0, stall_cycles4}, 32'd1);
    check("wrap_stall32", stall_cycles, 32'd17);
    check("wrap_pc4", {31'd0, pc_write4}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
